// File: rtl/piso_if.sv
// piso_if: parallel-load handshake and serial output bundle for piso_tx
//  d       parallel word to transmit
//  ld      load request, honoured only while rdy=1
//  clr     synchronous abort
//  rdy     transmitter idle, can accept a word
//  so      serial data bit, 0 whenever so_vld=0
//  so_vld  so carries a valid bit this cycle
//  done    one-cycle pulse after the last bit of a word
interface piso_if #(parameter int W = 8);
  logic [W-1:0] d;
  logic ld, clr, rdy, so, so_vld, done;
  modport master(output d, ld, clr, input rdy, so, so_vld, done);
  modport slave(input d, ld, clr, output rdy, so, so_vld, done);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter, one bit per clock with done pulse
//  clk    clock, all state changes on posedge
//  rst_b  synchronous active-low reset
//  s      piso_if slave: d/ld/clr in, rdy/so/so_vld/done out
module piso_tx #(
  parameter int W = 8,
  parameter bit MSB_FIRST = 0
) (
  input logic clk,
  input logic rst_b,
  piso_if.slave s
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] shreg, shreg_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n = cnt;
    if (s.clr) begin
      state_n = IDLE;
      shreg_n = '0;
      cnt_n = '0;
    end else begin
      case (state)
        IDLE: if (s.ld) begin
          state_n = SHIFT;
          shreg_n = s.d;
          cnt_n = CW'(W);
        end
        SHIFT: begin
          // shift toward the output end, zero-filling behind
          shreg_n = MSB_FIRST ? shreg << 1 : shreg >> 1;
          cnt_n = cnt - 1'b1;
          state_n = cnt == CW'(1) ? DONE : SHIFT;
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  assign s.rdy = state == IDLE;
  assign s.so_vld = state == SHIFT;
  assign s.done = state == DONE;
  assign s.so = s.so_vld & (MSB_FIRST ? shreg[W-1] : shreg[0]);
endmodule
